// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared encodings and defaults for the memory access controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    // Default register window: BASE_ADDR .. BASE_ADDR+NUM_REGS-1
    localparam int DEFAULT_BASE_ADDR = 32;
    localparam int DEFAULT_NUM_REGS  = 32;
    localparam int DEFAULT_WIDTH     = 16;

    // Request operation codes
    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

endpackage : mem_access_ctrl_pkg
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
// Module   : mem_addr_check
// Purpose  : Flags whether an address falls inside the register window.
// Revision : 1.0 - initial release
// ============================================================================
module mem_addr_check #(
    parameter int BASE_ADDR = 32,
    parameter int NUM_REGS  = 32,
    parameter int WIDTH     = 16
) (
    input  logic [WIDTH-1:0] addr,
    output logic             in_range
);

    // One extra bit so the upper bound cannot wrap when the window ends at 2**WIDTH
    localparam logic [WIDTH:0] LO = (WIDTH+1)'(BASE_ADDR);
    localparam logic [WIDTH:0] HI = (WIDTH+1)'(BASE_ADDR + NUM_REGS);

    assign in_range = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);

endmodule : mem_addr_check
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Sequences LOAD / STORE / MOVE requests onto a register bank with
//            a one-cycle read latency, and returns a held response.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int NUM_REGS  = DEFAULT_NUM_REGS,
    parameter int WIDTH     = DEFAULT_WIDTH
) (
    input  logic             b,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_src,
    input  logic [WIDTH-1:0] req_dst,
    input  logic [WIDTH-1:0] req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             mem_reg_read,
    output logic             mem_reg_write,
    output logic [WIDTH-1:0] read_address1,
    output logic [WIDTH-1:0] write_address,
    output logic [WIDTH-1:0] write_data,
    input  logic [WIDTH-1:0] out_data1
);

    state_e           state;
    op_e              op_q;
    logic [WIDTH-1:0] dst_q;
    logic [WIDTH-1:0] moved_q;

    logic             src_ok;
    logic             dst_ok;
    logic             req_bad;
    op_e              req_op_e;

    mem_addr_check #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .WIDTH     (WIDTH)
    ) u_src_check (
        .addr      (req_src),
        .in_range  (src_ok)
    );

    mem_addr_check #(
        .BASE_ADDR (BASE_ADDR),
        .NUM_REGS  (NUM_REGS),
        .WIDTH     (WIDTH)
    ) u_dst_check (
        .addr      (req_dst),
        .in_range  (dst_ok)
    );

    assign req_op_e = op_e'(req_op);

    // Only the addresses an operation actually uses are range-checked
    assign req_bad = (req_op_e == OP_RSVD)
                  || ((req_op_e != OP_STORE) && !src_ok)
                  || ((req_op_e != OP_LOAD)  && !dst_ok);

    // Ready follows the IDLE state and drops while reset is held
    assign req_ready = (state == ST_IDLE) && !reset;

    // Main sequencer: strobes are single-cycle pulses, address/data are zero when idle
    always_ff @(posedge b or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_q          <= OP_LOAD;
            dst_q         <= '0;
            moved_q       <= '0;
            mem_reg_read  <= 1'b0;
            mem_reg_write <= 1'b0;
            read_address1 <= '0;
            write_address <= '0;
            write_data    <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
        end else begin
            mem_reg_read  <= 1'b0;
            mem_reg_write <= 1'b0;
            read_address1 <= '0;
            write_address <= '0;
            write_data    <= '0;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op_e;
                        dst_q <= req_dst;
                        if (req_bad) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= '0;
                        end else if (req_op_e == OP_STORE) begin
                            state         <= ST_WRITE;
                            mem_reg_write <= 1'b1;
                            write_address <= req_dst;
                            write_data    <= req_data;
                        end else begin
                            state         <= ST_READ;
                            mem_reg_read  <= 1'b1;
                            read_address1 <= req_src;
                        end
                    end
                end

                // Bank returns data during the following cycle
                ST_READ: begin
                    state <= ST_CAPTURE;
                end

                ST_CAPTURE: begin
                    if (op_q == OP_MOVE) begin
                        state         <= ST_WRITE;
                        moved_q       <= out_data1;
                        mem_reg_write <= 1'b1;
                        write_address <= dst_q;
                        write_data    <= out_data1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= out_data1;
                        resp_err   <= 1'b0;
                    end
                end

                ST_WRITE: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= (op_q == OP_MOVE) ? moved_q : '0;
                    resp_err   <= 1'b0;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : mem_access_ctrl
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl with a transaction-level
//            model and a behavioural register bank.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_src;
    logic [15:0] req_dst;
    logic [15:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        mem_reg_read;
    logic        mem_reg_write;
    logic [15:0] read_address1;
    logic [15:0] write_address;
    logic [15:0] write_data;
    logic [15:0] out_data1;

    typedef struct packed {
        logic        rd;
        logic [15:0] ra;
        logic        wr;
        logic [15:0] wa;
        logic [15:0] wd;
        logic        rv;
        logic [15:0] rdat;
        logic        re;
        logic        rdy;
    } exp_t;

    exp_t        want;
    exp_t        idle_exp;
    logic [15:0] bank [256];
    logic [15:0] mdl  [256];
    int          wr_cnt, rd_cnt;
    logic [15:0] last_wr_addr, last_wr_data, last_rd_addr;
    logic [15:0] last_rdata;
    logic        last_err, last_valid;
    int          n_tests, n_fail;

    mem_access_ctrl #(
        .BASE_ADDR (32),
        .NUM_REGS  (32),
        .WIDTH     (16)
    ) dut (
        .b             (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_src       (req_src),
        .req_dst       (req_dst),
        .req_data      (req_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .mem_reg_read  (mem_reg_read),
        .mem_reg_write (mem_reg_write),
        .read_address1 (read_address1),
        .write_address (write_address),
        .write_data    (write_data),
        .out_data1     (out_data1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register bank: one-cycle read latency, counts strobes
    always @(posedge clk) begin
        if (mem_reg_read) begin
            out_data1    <= bank[read_address1[7:0]];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= read_address1;
        end
        if (mem_reg_write) begin
            bank[write_address[7:0]] <= write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= write_address;
            last_wr_data <= write_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Every cycle, mid-period: all outputs against the model's expectation
    always @(negedge clk) begin
        check("req_ready",     32'(req_ready),     32'(want.rdy));
        check("mem_reg_read",  32'(mem_reg_read),  32'(want.rd));
        check("read_address1", 32'(read_address1), 32'(want.ra));
        check("mem_reg_write", 32'(mem_reg_write), 32'(want.wr));
        check("write_address", 32'(write_address), 32'(want.wa));
        check("write_data",    32'(write_data),    32'(want.wd));
        check("resp_valid",    32'(resp_valid),    32'(want.rv));
        check("resp_data",     32'(resp_data),     32'(want.rdat));
        check("resp_err",      32'(resp_err),      32'(want.re));
    end

    function automatic logic in_rng(input logic [15:0] a);
        return (a >= 16'd32) && (a < 16'd64);
    endfunction

    // One request through to response handshake; hold = extra RESP cycles with resp_ready low
    task automatic run_txn(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] data, input int hold, input logic busy_req);
        logic        bad;
        int          lat;
        logic [15:0] val;
        exp_t        e;
        bad = (op == 2'b11) || ((op != 2'b01) && !in_rng(src)) || ((op != 2'b00) && !in_rng(dst));
        val = 16'd0;
        lat = 1;
        if (!bad) begin
            case (op)
                2'b00:   begin lat = 3; val = mdl[src[7:0]]; end
                2'b01:   begin lat = 2; val = 16'd0; end
                default: begin lat = 4; val = mdl[src[7:0]]; end
            endcase
        end
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_data  = data;
        @(posedge clk); #1;
        // Optional competing request while busy: must be ignored
        req_valid = busy_req;
        req_op    = 2'b01;
        req_dst   = 16'd40;
        req_data  = 16'hdead;
        for (int k = 1; k <= lat + hold; k++) begin
            e = '0;
            if (!bad) begin
                if (k == 1 && op != 2'b01) begin e.rd = 1'b1; e.ra = src; end
                if (k == 1 && op == 2'b01) begin e.wr = 1'b1; e.wa = dst; e.wd = data; end
                if (k == 3 && op == 2'b10) begin e.wr = 1'b1; e.wa = dst; e.wd = val; end
            end
            if (k >= lat) begin e.rv = 1'b1; e.rdat = val; e.re = bad; end
            want       = e;
            resp_ready = (k == lat + hold);
            if (k == lat) begin
                @(negedge clk);
                last_rdata = resp_data;
                last_err   = resp_err;
                last_valid = resp_valid;
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        want       = idle_exp;
        if (!bad && op == 2'b01) mdl[dst[7:0]] = data;
        if (!bad && op == 2'b10) mdl[dst[7:0]] = val;
    endtask

    initial begin
        int wc, rc;
        n_tests    = 0;
        n_fail     = 0;
        wr_cnt     = 0;
        rd_cnt     = 0;
        out_data1  = '0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_src    = '0;
        req_dst    = '0;
        req_data   = '0;
        resp_ready = 1'b0;
        want       = '0;
        idle_exp   = '0;
        idle_exp.rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bank[i] = 16'(i * 7 + 100);
            mdl[i]  = 16'(i * 7 + 100);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        want  = idle_exp;
        @(posedge clk); #1;

        // STORE 48=23 then LOAD 48
        wc = wr_cnt;
        run_txn(2'b01, 16'd0, 16'd48, 16'd23, 0, 1'b0);
        check("store_wr_count", 32'(wr_cnt - wc), 32'd1);
        check("store_wr_addr",  32'(last_wr_addr), 32'd48);
        check("store_wr_data",  32'(last_wr_data), 32'd23);
        run_txn(2'b00, 16'd48, 16'd0, 16'd0, 0, 1'b0);
        check("load48_valid_c3", 32'(last_valid), 32'd1);
        check("load48_data",     32'(last_rdata), 32'd23);
        check("load48_err",      32'(last_err),   32'd0);

        // MOVE 48 -> 52, then LOAD 52
        wc = wr_cnt; rc = rd_cnt;
        run_txn(2'b10, 16'd48, 16'd52, 16'd0, 0, 1'b0);
        check("move_rd_count", 32'(rd_cnt - rc), 32'd1);
        check("move_wr_count", 32'(wr_cnt - wc), 32'd1);
        check("move_rd_addr",  32'(last_rd_addr), 32'd48);
        check("move_wr_addr",  32'(last_wr_addr), 32'd52);
        check("move_wr_data",  32'(last_wr_data), 32'd23);
        check("move_resp",     32'(last_rdata),   32'd23);
        run_txn(2'b00, 16'd52, 16'd0, 16'd0, 0, 1'b0);
        check("load52_data", 32'(last_rdata), 32'd23);

        // Rejected requests: no strobes, zero data, error flagged
        wc = wr_cnt; rc = rd_cnt;
        run_txn(2'b00, 16'd31, 16'd0, 16'd0, 0, 1'b0);
        check("load31_err",  32'(last_err),   32'd1);
        check("load31_data", 32'(last_rdata), 32'd0);
        run_txn(2'b01, 16'd0, 16'd64, 16'd5, 0, 1'b0);
        check("store64_err", 32'(last_err), 32'd1);
        run_txn(2'b11, 16'd40, 16'd40, 16'd5, 0, 1'b0);
        check("op11_err", 32'(last_err), 32'd1);
        run_txn(2'b10, 16'd50, 16'd70, 16'd0, 0, 1'b0);
        check("move_dst_oob_err", 32'(last_err), 32'd1);
        check("err_no_strobes", 32'((wr_cnt - wc) + (rd_cnt - rc)), 32'd0);

        // Window edges and src==dst move
        run_txn(2'b00, 16'd63, 16'd0, 16'd0, 0, 1'b0);
        check("load63_data", 32'(last_rdata), 32'd541);
        run_txn(2'b01, 16'd0, 16'd32, 16'h1234, 0, 1'b0);
        run_txn(2'b00, 16'd32, 16'd0, 16'd0, 0, 1'b0);
        check("load32_data", 32'(last_rdata), 32'h1234);
        run_txn(2'b10, 16'd40, 16'd40, 16'd0, 0, 1'b0);
        check("move_same_data", 32'(last_rdata), 32'd380);

        // Back-pressure: response held 5 cycles while a new request waits
        run_txn(2'b01, 16'd0, 16'd33, 16'd77, 5, 1'b1);
        run_txn(2'b00, 16'd33, 16'd0, 16'd0, 3, 1'b1);
        check("held_load33", 32'(last_rdata), 32'd77);

        // Reset during MOVE CAPTURE: abandoned, target untouched
        wc = wr_cnt;
        req_valid = 1'b1; req_op = 2'b10; req_src = 16'd48; req_dst = 16'd56; req_data = 16'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        want = '0; want.rd = 1'b1; want.ra = 16'd48;
        @(posedge clk); #1;
        want = '0;
        @(negedge clk); #1;
        reset = 1'b1;
        want  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        want  = idle_exp;
        repeat (3) @(posedge clk);
        #1;
        check("reset_no_write", 32'(wr_cnt - wc), 32'd0);
        run_txn(2'b00, 16'd56, 16'd0, 16'd0, 0, 1'b0);
        check("load56_unchanged", 32'(last_rdata), 32'd492);
        run_txn(2'b00, 16'd52, 16'd0, 16'd0, 0, 1'b0);
        check("load52_after_reset", 32'(last_rdata), 32'd23);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_access_ctrl
`default_nettype wire
